// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit data memory.
// Issue latency 1 cycle (registered); read data returns RD_LAT cycles after mem_en via a tag pipeline.
// Backpressure: req/gnt handshake, a port is ineligible in its own grant cycle; optional MEM_ARB_BOUNDS_CHECK_EN.
module mem_port_arbiter #(
   parameter int MEM_SIZE = 1024,
   parameter int RD_LAT   = 1,
   localparam int AW      = $clog2(MEM_SIZE)
) (
   input  logic          CLK,
   input  logic          RST,
   // port 0: loader / host
   input  logic          req0,
   input  logic          we0,
   input  logic [31:0]   addr0,
   input  logic [31:0]   wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [31:0]   rdata0,
   // port 1: execution core
   input  logic          req1,
   input  logic          we1,
   input  logic [31:0]   addr1,
   input  logic [31:0]   wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [31:0]   rdata1,
   // memory side
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          err
);

   // One entry per issued access, travelling alongside the memory read latency.
   typedef struct packed {
      logic vld;   // a read was issued (writes carry vld=0)
      logic port;  // requesting port index
      logic oob;   // out-of-range access: return zero instead of memory data
   } tag_t;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic          r_last;      // index of the most recently granted port
   logic          r_gnt0;
   logic          r_gnt1;

   logic          w_elig0;
   logic          w_elig1;
   logic          w_win_vld;
   logic          w_win_port;
   logic          w_sel_we;
   logic [31:0]   w_sel_addr;
   logic [31:0]   w_sel_wdata;
   logic          w_oob;

   // A port's req is stale during its own grant cycle, so it cannot win twice in a row.
   assign w_elig0 = req0 & ~r_gnt0;
   assign w_elig1 = req1 & ~r_gnt1;

   // Pick the winner (round-robin on a tie) and mux its request fields.
   always_comb begin
      w_win_vld   = w_elig0 | w_elig1;
      w_win_port  = 1'b0;
      if (w_elig0 && w_elig1) begin
         w_win_port = ~r_last;
      end else if (w_elig1) begin
         w_win_port = 1'b1;
      end
      w_sel_we    = w_win_port ? we1    : we0;
      w_sel_addr  = w_win_port ? addr1  : addr0;
      w_sel_wdata = w_win_port ? wdata1 : wdata0;
   end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
   // Full 32-bit compare so a non-power-of-two depth is also covered.
   assign w_oob = w_win_vld && (w_sel_addr >= 32'(MEM_SIZE));
`else
   // Upper address bits are ignored; accesses wrap on the low AW bits.
   assign w_oob = 1'b0;
   logic w_unused_hi_addr;
   assign w_unused_hi_addr = ^{addr0[31:AW], addr1[31:AW]};
`endif

   // ------------------------------------------------------------------
   // Registered issue
   // ------------------------------------------------------------------
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic          r_iss_rd;    // a read (in or out of range) was granted this cycle
   logic          r_iss_port;
   logic          r_iss_oob;

   // Register the winning access for one cycle; out-of-range accesses never strobe memory.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_last      <= 1'b1;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_iss_rd    <= 1'b0;
         r_iss_port  <= 1'b0;
         r_iss_oob   <= 1'b0;
      end else begin
         r_gnt0      <= w_win_vld & ~w_win_port;
         r_gnt1      <= w_win_vld &  w_win_port;
         r_mem_en    <= w_win_vld & ~w_oob;
         r_mem_we    <= w_win_vld & ~w_oob & w_sel_we;
         r_iss_rd    <= w_win_vld & ~w_sel_we;
         r_iss_port  <= w_win_port;
         r_iss_oob   <= w_oob;
         if (w_win_vld) begin
            r_last      <= w_win_port;
            r_mem_addr  <= w_sel_addr[AW-1:0];
            r_mem_wdata <= w_sel_wdata;
         end
      end
   end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
   logic r_err;

   // Flag an out-of-range access in its grant cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_oob;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // ------------------------------------------------------------------
   // Read-return tag pipeline
   // ------------------------------------------------------------------
   // Stage 0 is loaded from the issue registers, so the last stage lines up
   // with mem_rdata exactly RD_LAT cycles after the mem_en cycle.
   tag_t r_tag [RD_LAT];

   // Shift the tags; reset drops every in-flight read.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= '{vld: r_iss_rd, port: r_iss_port, oob: r_iss_oob};
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   tag_t        w_ret;
   logic [31:0] w_ret_data;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;

   assign w_ret      = r_tag[RD_LAT-1];
   assign w_ret_data = w_ret.oob ? 32'h0 : mem_rdata;
   assign rvalid0    = w_ret.vld & ~w_ret.port;
   assign rvalid1    = w_ret.vld &  w_ret.port;

   // Remember the last returned word per port so rdata holds between returns.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (rvalid0) begin
            r_rdata0 <= w_ret_data;
         end
         if (rvalid1) begin
            r_rdata1 <= w_ret_data;
         end
      end
   end

   // Returning data passes straight through in its valid cycle.
   assign rdata0 = rvalid0 ? w_ret_data : r_rdata0;
   assign rdata1 = rvalid1 ? w_ret_data : r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_SIZE=1024, RD_LAT=2) with a 2-cycle memory model.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Bounds-check expectations follow MEM_ARB_BOUNDS_CHECK_EN.
module tb_mem_port_arbiter;
   localparam int MEM_SIZE = 1024;
   localparam int RD_LAT   = 2;
   localparam int AW       = $clog2(MEM_SIZE);

   logic          CLK;
   logic          RST;
   logic          req0, we0, req1, we1;
   logic [31:0]   addr0, wdata0, addr1, wdata1;
   logic          gnt0, rvalid0, gnt1, rvalid1;
   logic [31:0]   rdata0, rdata1;
   logic          mem_en, mem_we, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .RD_LAT(RD_LAT)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model with a fixed 2-cycle read latency; reset preloads A5A5_0000 | index.
   logic [31:0]   mem [0:MEM_SIZE-1];
   logic [AW-1:0] ap0, ap1;
   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'hA5A50000 | 32'(i);
         ap0 <= '0;
         ap1 <= '0;
      end else begin
         if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
         ap0 <= mem_addr;
         ap1 <= ap0;
      end
   end
   assign mem_rdata = mem[ap1];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      repeat (3) tick();
      RST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl cycle %0d: got %b want 0000000", c,
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, err});
         end
         total++;
         if ({mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL reset_data cycle %0d: addr=%h wdata=%h rd0=%h rd1=%h want all 0",
                     c, mem_addr, mem_wdata, rdata0, rdata1);
         end
      end
   endtask

   task automatic test_write();
      req0 = 1; we0 = 1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
      tick();
      total++;
      if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1011) begin
         bad++;
         $display("FAIL write_issue: gnt0,gnt1,en,we=%b want 1011", {gnt0, gnt1, mem_en, mem_we});
      end
      total++;
      if (mem_addr !== 10'd5 || mem_wdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL write_bus: addr=%0d wdata=%h want 5 deadbeef", mem_addr, mem_wdata);
      end
      tick();
      req0 = 0;
      total++;
      if ({gnt0, mem_en, mem_we} !== 3'b000) begin
         bad++;
         $display("FAIL write_one_cycle: gnt0,en,we=%b want 000", {gnt0, mem_en, mem_we});
      end
      repeat (3) tick();
      total++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         bad++;
         $display("FAIL write_no_rvalid: rvalid0,1=%b want 00", {rvalid0, rvalid1});
      end
   endtask

   task automatic test_read();
      req1 = 1; we1 = 0; addr1 = 32'd5;
      tick();
      total++;
      if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0110 || mem_addr !== 10'd5) begin
         bad++;
         $display("FAIL read_issue: gnt0,gnt1,en,we=%b addr=%0d want 0110 5",
                  {gnt0, gnt1, mem_en, mem_we}, mem_addr);
      end
      tick();
      req1 = 0;
      total++;
      if ({gnt1, rvalid0, rvalid1} !== 3'b000) begin
         bad++;
         $display("FAIL read_early: gnt1,rvalid0,rvalid1=%b want 000", {gnt1, rvalid0, rvalid1});
      end
      tick();
      total++;
      if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL read_return: rvalid0,1=%b rdata1=%h want 01 deadbeef",
                  {rvalid0, rvalid1}, rdata1);
      end
      tick();
      total++;
      if (rvalid1 !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL read_hold: rvalid1=%b rdata1=%h want 0 deadbeef", rvalid1, rdata1);
      end
   endtask

   // A single port holding req is granted every other cycle.
   task automatic test_lone_throughput();
      req0 = 1; we0 = 1; addr0 = 32'd9; wdata0 = 32'h99;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (gnt0 !== ((i % 2) == 0)) begin
            bad++;
            $display("FAIL lone_gnt cycle %0d: gnt0=%b want %b", i, gnt0, (i % 2) == 0);
         end
      end
      req0 = 0;
      tick();
      total++;
      if (gnt0 !== 1'b0) begin
         bad++;
         $display("FAIL lone_release: gnt0=%b want 0", gnt0);
      end
      repeat (2) tick();
   endtask

   // Both ports reading back to back right after reset: 0,1,0,1,... and memory busy every cycle.
   task automatic test_back_to_back();
      logic exp0;
      RST = 1;
      tick();
      RST = 0;
      req0 = 1; we0 = 0; addr0 = 32'd1;
      req1 = 1; we1 = 0; addr1 = 32'd2;
      for (int i = 0; i < 7; i++) begin
         tick();
         exp0 = ((i % 2) == 0);
         total++;
         if ({gnt0, gnt1} !== {exp0, ~exp0} || mem_en !== 1'b1) begin
            bad++;
            $display("FAIL rr_grant cycle %0d: gnt0,gnt1=%b en=%b want %b%b 1",
                     i, {gnt0, gnt1}, mem_en, exp0, ~exp0);
         end
         total++;
         if (mem_addr !== (exp0 ? 10'd1 : 10'd2)) begin
            bad++;
            $display("FAIL rr_addr cycle %0d: addr=%0d want %0d", i, mem_addr, exp0 ? 1 : 2);
         end
         if (i >= 2) begin
            total++;
            if ({rvalid0, rvalid1} !== {exp0, ~exp0} ||
                (exp0 && rdata0 !== 32'hA5A50001) || (!exp0 && rdata1 !== 32'hA5A50002)) begin
               bad++;
               $display("FAIL rr_return cycle %0d: rvalid0,1=%b rd0=%h rd1=%h want %b%b a5a50001/a5a50002",
                        i, {rvalid0, rvalid1}, rdata0, rdata1, exp0, ~exp0);
            end
         end else begin
            total++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
               bad++;
               $display("FAIL rr_return_early cycle %0d: rvalid0,1=%b want 00", i, {rvalid0, rvalid1});
            end
         end
      end
      // Port 0 was granted last; the still-pending port 1 request is served next.
      tick();
      req0 = 0;
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("FAIL rr_pending: gnt0,gnt1=%b want 01", {gnt0, gnt1});
      end
      tick();
      req1 = 0;
      total++;
      if ({gnt0, gnt1} !== 2'b00) begin
         bad++;
         $display("FAIL rr_drain: gnt0,gnt1=%b want 00", {gnt0, gnt1});
      end
      repeat (4) tick();
   endtask

   // Reset during the read window drops the return and restores port 0 priority.
   task automatic test_reset_midflight();
      req1 = 1; we1 = 0; addr1 = 32'd7;
      tick();
      total++;
      if (gnt1 !== 1'b1) begin
         bad++;
         $display("FAIL mid_issue: gnt1=%b want 1", gnt1);
      end
      tick();
      req1 = 0;
      RST = 1;
      #1;
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, err} !== 7'b0 ||
          {mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
         bad++;
         $display("FAIL mid_async_reset: ctrl=%b addr=%h wdata=%h rd0=%h rd1=%h want all 0",
                  {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, err},
                  mem_addr, mem_wdata, rdata0, rdata1);
      end
      tick();
      RST = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if ({rvalid0, rvalid1} !== 2'b00) begin
            bad++;
            $display("FAIL mid_dropped cycle %0d: rvalid0,1=%b want 00", c, {rvalid0, rvalid1});
         end
      end
      req0 = 1; we0 = 0; addr0 = 32'd3;
      req1 = 1; we1 = 0; addr1 = 32'd4;
      tick();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("FAIL mid_tie: gnt0,gnt1=%b want 10", {gnt0, gnt1});
      end
      tick();
      req0 = 0;
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("FAIL mid_tie_next: gnt0,gnt1=%b want 01", {gnt0, gnt1});
      end
      tick();
      req1 = 0;
      repeat (4) tick();
   endtask

   task automatic test_bounds();
      req0 = 1; we0 = 0; addr0 = 32'd1024;
      tick();
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      total++;
      if ({gnt0, err, mem_en, mem_we} !== 4'b1100) begin
         bad++;
         $display("FAIL oob_issue: gnt0,err,en,we=%b want 1100", {gnt0, err, mem_en, mem_we});
      end
`else
      total++;
      if ({gnt0, err, mem_en, mem_we} !== 4'b1010 || mem_addr !== 10'd0) begin
         bad++;
         $display("FAIL wrap_issue: gnt0,err,en,we=%b addr=%0d want 1010 0",
                  {gnt0, err, mem_en, mem_we}, mem_addr);
      end
`endif
      tick();
      req0 = 0;
      total++;
      if ({gnt0, err} !== 2'b00) begin
         bad++;
         $display("FAIL oob_one_cycle: gnt0,err=%b want 00", {gnt0, err});
      end
      tick();
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      total++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
         bad++;
         $display("FAIL oob_return: rvalid0=%b rdata0=%h want 1 00000000", rvalid0, rdata0);
      end
`else
      total++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A50000) begin
         bad++;
         $display("FAIL wrap_return: rvalid0=%b rdata0=%h want 1 a5a50000", rvalid0, rdata0);
      end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_lone_throughput();
      test_back_to_back();
      test_reset_midflight();
      test_bounds();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
